// File: rtl/spi_slave_pkg.sv
// Shared SPI slave definitions.
// Holds the slave register addresses, CTRL/CONFIG bit positions, the
// state encoding and a CTRL packing helper so that the slave, the
// host-side software model and the testbench agree on one register map.
package spi_slave_pkg;

  // Register addresses
  localparam logic [1:0] SPIS_CTRL   = 2'd0;
  localparam logic [1:0] SPIS_CONFIG = 2'd1;
  localparam logic [1:0] SPIS_TXBUF  = 2'd2;
  localparam logic [1:0] SPIS_RXBUF  = 2'd3;

  // CTRL bit positions
  localparam int unsigned SPIS_CTRL_EN      = 0;
  localparam int unsigned SPIS_CTRL_IRQEN   = 1;
  localparam int unsigned SPIS_CTRL_TXEMPTY = 4;
  localparam int unsigned SPIS_CTRL_OVR     = 5;
  localparam int unsigned SPIS_CTRL_RXV     = 6;
  localparam int unsigned SPIS_CTRL_BUSY    = 7;

  // CONFIG bit positions: MODE = {CPOL, CPHA}
  localparam int unsigned SPIS_CFG_CPHA = 4;
  localparam int unsigned SPIS_CFG_CPOL = 5;

  typedef enum logic [1:0] {
    SPIS_ST_DISABLED = 2'd0,
    SPIS_ST_IDLE     = 2'd1,
    SPIS_ST_ACTIVE   = 2'd2
  } spis_state_e;

  // Assemble the CTRL read value from its individual flags.
  function automatic logic [7:0] spis_ctrl_pack(
    input logic en,
    input logic irqen,
    input logic txempty,
    input logic ovr,
    input logic rxv,
    input logic busy
  );
    logic [7:0] v;
    v = 8'h00;
    v[SPIS_CTRL_EN]      = en;
    v[SPIS_CTRL_IRQEN]   = irqen;
    v[SPIS_CTRL_TXEMPTY] = txempty;
    v[SPIS_CTRL_OVR]     = ovr;
    v[SPIS_CTRL_RXV]     = rxv;
    v[SPIS_CTRL_BUSY]    = busy;
    return v;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer with a third stage for edge detection.
// Ports:
//   clk_i   system clock
//   rst_ni  synchronous reset, active low (all stages preset to INIT)
//   d_i     asynchronous input
//   q_o     synchronized level
//   rise_o  one-cycle pulse on a synchronized 0->1 transition
//   fall_o  one-cycle pulse on a synchronized 1->0 transition
module spi_sync_edge #(
  parameter logic INIT = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [2:0] sync_q;
  logic [2:0] sync_d;

  assign sync_d = {sync_q[1:0], d_i};

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_q <= {3{INIT}};
    end else begin
      sync_q <= sync_d;
    end
  end

  // Stage 1 is the synchronized level; stage 2 is the previous level.
  assign q_o    = sync_q[1];
  assign rise_o = sync_q[1] & ~sync_q[2];
  assign fall_o = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/spi_slave.sv
// SPI slave with a small register interface.
// Ports:
//   Clk, Rst_n        system clock, synchronous active-low reset
//   Addr, Wr, DataWr  register write port (write on Clk edge with Wr=1)
//   DataRd            combinational read of the register selected by Addr
//   SCK, MOSI, CS     SPI inputs from the master (asynchronous to Clk)
//   MISO, MISO_En     serial data to the master and its drive enable
//   Irq               registered IRQEN & (RXV | OVR)
// Registers: CTRL (EN, IRQEN, TXEMPTY, OVR, RXV, BUSY), CONFIG (MODE),
// TXBUF, RXBUF. All four SPI modes, MSB first, 8-bit bytes.
module spi_slave
  import spi_slave_pkg::*;
(
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic [1:0] Addr,
  input  logic       Wr,
  input  logic [7:0] DataWr,
  output logic [7:0] DataRd,
  input  logic       SCK,
  input  logic       MOSI,
  input  logic       CS,
  output logic       MISO,
  output logic       MISO_En,
  output logic       Irq
);

  // Synchronized SPI inputs
  logic sck_lvl, sck_rise, sck_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic mosi_lvl, mosi_rise, mosi_fall;
  logic unused_sync;

  spi_sync_edge #(.INIT(1'b0)) u_sync_sck (
    .clk_i  (Clk),
    .rst_ni (Rst_n),
    .d_i    (SCK),
    .q_o    (sck_lvl),
    .rise_o (sck_rise),
    .fall_o (sck_fall)
  );

  spi_sync_edge #(.INIT(1'b1)) u_sync_cs (
    .clk_i  (Clk),
    .rst_ni (Rst_n),
    .d_i    (CS),
    .q_o    (cs_lvl),
    .rise_o (cs_rise),
    .fall_o (cs_fall)
  );

  spi_sync_edge #(.INIT(1'b0)) u_sync_mosi (
    .clk_i  (Clk),
    .rst_ni (Rst_n),
    .d_i    (MOSI),
    .q_o    (mosi_lvl),
    .rise_o (mosi_rise),
    .fall_o (mosi_fall)
  );

  // The CS level (not its rising pulse) ends a transfer, so these are spare.
  assign unused_sync = ^{sck_lvl, cs_rise, mosi_rise, mosi_fall};

  // State and registers
  spis_state_e state_q, state_d;
  logic        en_q, en_d;
  logic        irqen_q, irqen_d;
  logic        txempty_q, txempty_d;
  logic        ovr_q, ovr_d;
  logic        rxv_q, rxv_d;
  logic [1:0]  mode_q, mode_d;
  logic [7:0]  txbuf_q, txbuf_d;
  logic [7:0]  rxbuf_q, rxbuf_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic        miso_q, miso_d;
  logic        irq_q, irq_d;

  logic cpol, cpha;
  logic lead_edge, trail_edge;
  logic sample_edge, shift_edge;
  logic busy;

  assign cpol = mode_q[1];
  assign cpha = mode_q[0];

  // Leading edge leaves the idle (CPOL) level; trailing edge returns to it.
  assign lead_edge   = cpol ? sck_fall : sck_rise;
  assign trail_edge  = cpol ? sck_rise : sck_fall;
  assign sample_edge = cpha ? trail_edge : lead_edge;
  assign shift_edge  = cpha ? lead_edge  : trail_edge;

  assign busy = (state_q == SPIS_ST_ACTIVE);

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q    <= SPIS_ST_DISABLED;
      en_q       <= 1'b0;
      irqen_q    <= 1'b0;
      txempty_q  <= 1'b1;
      ovr_q      <= 1'b0;
      rxv_q      <= 1'b0;
      mode_q     <= 2'b00;
      txbuf_q    <= 8'h00;
      rxbuf_q    <= 8'h00;
      tx_shift_q <= 8'h00;
      rx_shift_q <= 8'h00;
      bit_cnt_q  <= 3'd0;
      miso_q     <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      en_q       <= en_d;
      irqen_q    <= irqen_d;
      txempty_q  <= txempty_d;
      ovr_q      <= ovr_d;
      rxv_q      <= rxv_d;
      mode_q     <= mode_d;
      txbuf_q    <= txbuf_d;
      rxbuf_q    <= rxbuf_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      bit_cnt_q  <= bit_cnt_d;
      miso_q     <= miso_d;
      irq_q      <= irq_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    en_d       = en_q;
    irqen_d    = irqen_q;
    txempty_d  = txempty_q;
    ovr_d      = ovr_q;
    rxv_d      = rxv_q;
    mode_d     = mode_q;
    txbuf_d    = txbuf_q;
    rxbuf_d    = rxbuf_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    bit_cnt_d  = bit_cnt_q;
    miso_d     = miso_q;

    // Host writes first; the transfer logic below runs afterwards so that
    // a hardware set of RXV/OVR in the same cycle overrides a W1C clear.
    if (Wr) begin
      case (Addr)
        SPIS_CTRL: begin
          en_d    = DataWr[SPIS_CTRL_EN];
          irqen_d = DataWr[SPIS_CTRL_IRQEN];
          if (DataWr[SPIS_CTRL_OVR]) ovr_d = 1'b0;
          if (DataWr[SPIS_CTRL_RXV]) rxv_d = 1'b0;
        end
        SPIS_CONFIG: begin
          // Mode must stay stable for the whole transfer.
          if (!busy) mode_d = DataWr[SPIS_CFG_CPOL:SPIS_CFG_CPHA];
        end
        SPIS_TXBUF: begin
          txbuf_d   = DataWr;
          txempty_d = 1'b0;
        end
        default: ;  // RXBUF is read-only
      endcase
    end

    case (state_q)
      SPIS_ST_DISABLED: begin
        bit_cnt_d = 3'd0;
        if (en_q) state_d = SPIS_ST_IDLE;
      end

      SPIS_ST_IDLE: begin
        bit_cnt_d = 3'd0;
        if (!en_q) begin
          state_d = SPIS_ST_DISABLED;
        end else if (cs_fall) begin
          state_d   = SPIS_ST_ACTIVE;
          txempty_d = 1'b1;
          miso_d    = txbuf_q[7];
          // CPHA=0 has bit7 on the line already, so the first shift edge
          // must move on to bit6. CPHA=1 drives bit7 on the first leading edge.
          tx_shift_d = cpha ? txbuf_q : {txbuf_q[6:0], 1'b0};
        end
      end

      SPIS_ST_ACTIVE: begin
        if (!en_q) begin
          state_d   = SPIS_ST_DISABLED;
          bit_cnt_d = 3'd0;
        end else if (cs_lvl) begin
          // Deselected: any partial byte is dropped.
          state_d   = SPIS_ST_IDLE;
          bit_cnt_d = 3'd0;
        end else begin
          if (sample_edge) begin
            rx_shift_d = {rx_shift_q[6:0], mosi_lvl};
            bit_cnt_d  = bit_cnt_q + 3'd1;  // wraps to 0 after the 8th bit
            if (bit_cnt_q == 3'd7) begin
              rxbuf_d    = {rx_shift_q[6:0], mosi_lvl};
              rxv_d      = 1'b1;
              if (rxv_q) ovr_d = 1'b1;
              // Full reload: the next shift edge drives the new bit7.
              tx_shift_d = txbuf_q;
              txempty_d  = 1'b1;
            end
          end
          if (shift_edge) begin
            miso_d     = tx_shift_q[7];
            tx_shift_d = {tx_shift_q[6:0], 1'b0};
          end
        end
      end

      default: begin
        state_d = SPIS_ST_DISABLED;
      end
    endcase

    // Registered from the next-state flags so Irq tracks the visible flags.
    irq_d = irqen_d & (rxv_d | ovr_d);
  end

  always_comb begin
    DataRd = 8'h00;
    case (Addr)
      SPIS_CTRL:   DataRd = spis_ctrl_pack(en_q, irqen_q, txempty_q, ovr_q, rxv_q, busy);
      SPIS_CONFIG: DataRd = {2'b00, mode_q, 4'b0000};
      SPIS_TXBUF:  DataRd = txbuf_q;
      SPIS_RXBUF:  DataRd = rxbuf_q;
      default:     DataRd = 8'h00;
    endcase
  end

  assign MISO_En = busy;
  assign MISO    = miso_q & busy;
  assign Irq     = irq_q;

endmodule

// File: tb/tb_spi_slave.sv
// Testbench for spi_slave: directed mode table, overrun, abort,
// protection, reset mid-byte and randomized multi-byte transfers checked
// against a byte-level model of the slave.
module tb_spi_slave;

  localparam int HALF = 8;  // SCK half period in Clk cycles (SCK = Clk/16)

  logic       Clk = 1'b0;
  logic       Rst_n;
  logic [1:0] Addr;
  logic       Wr;
  logic [7:0] DataWr;
  logic [7:0] DataRd;
  logic       SCK;
  logic       MOSI;
  logic       CS;
  logic       MISO;
  logic       MISO_En;
  logic       Irq;

  int vectors     = 0;
  int miscompares = 0;

  always #5 Clk = ~Clk;

  spi_slave dut (
    .Clk     (Clk),
    .Rst_n   (Rst_n),
    .Addr    (Addr),
    .Wr      (Wr),
    .DataWr  (DataWr),
    .DataRd  (DataRd),
    .SCK     (SCK),
    .MOSI    (MOSI),
    .CS      (CS),
    .MISO    (MISO),
    .MISO_En (MISO_En),
    .Irq     (Irq)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%02h", name, act);
    end
  endtask

  task automatic wait_half();
    repeat (HALF) @(negedge Clk);
  endtask

  task automatic reg_wr(input logic [1:0] a, input logic [7:0] d);
    @(negedge Clk);
    Addr = a; DataWr = d; Wr = 1'b1;
    @(negedge Clk);
    Wr = 1'b0;
  endtask

  task automatic reg_rd(input logic [1:0] a, output logic [7:0] d);
    @(negedge Clk);
    Addr = a;
    #1;
    d = DataRd;
  endtask

  task automatic set_mode(input logic [1:0] m);
    reg_wr(2'd1, {2'b00, m, 4'b0000});
    SCK = m[1];
    wait_half();
  endtask

  task automatic cs_low();
    wait_half();
    CS = 1'b0;
    wait_half();
  endtask

  task automatic cs_high();
    wait_half();
    CS = 1'b1;
    wait_half();
  endtask

  // Master side of one byte (or the first nbits of it), MSB first.
  task automatic xfer(input logic [1:0] mode, input logic [7:0] tx,
                      input int nbits, output logic [7:0] rx);
    logic cpol, cpha;
    cpol = mode[1];
    cpha = mode[0];
    rx = 8'h00;
    for (int b = 7; b >= 8 - nbits; b--) begin
      if (!cpha) begin
        MOSI = tx[b];
        wait_half();
        rx[b] = MISO;
        SCK = ~cpol;
        wait_half();
        SCK = cpol;
      end else begin
        SCK = ~cpol;
        MOSI = tx[b];
        wait_half();
        rx[b] = MISO;
        SCK = cpol;
        wait_half();
      end
    end
  endtask

  typedef struct packed {
    logic [1:0] mode;
    logic [7:0] txbuf;
    logic [7:0] mosi;
    logic [7:0] exp_miso;
    logic [7:0] exp_rxbuf;
    logic [7:0] exp_ctrl;
  } vec_t;

  vec_t vecs [4];

  initial begin
    logic [7:0] rd, r1, r2;
    logic [7:0] sent_q [$];
    logic [1:0] m;
    logic [7:0] txv, bv, exp_ctrl;
    int nb;

    // CTRL after one received byte with IRQEN=0: EN|TXEMPTY|RXV
    vecs[0] = '{2'd0, 8'hAA, 8'hBB, 8'hAA, 8'hBB, 8'h51};
    vecs[1] = '{2'd1, 8'h72, 8'hBB, 8'h72, 8'hBB, 8'h51};
    vecs[2] = '{2'd2, 8'hC3, 8'hBB, 8'hC3, 8'hBB, 8'h51};
    vecs[3] = '{2'd3, 8'h5D, 8'hBB, 8'h5D, 8'hBB, 8'h51};

    Rst_n = 1'b0; Wr = 1'b0; Addr = 2'd0; DataWr = 8'h00;
    SCK = 1'b0; MOSI = 1'b0; CS = 1'b1;
    repeat (4) @(negedge Clk);
    check("reset MISO_En", {7'd0, MISO_En}, 8'h00);
    check("reset MISO", {7'd0, MISO}, 8'h00);
    check("reset Irq", {7'd0, Irq}, 8'h00);
    Rst_n = 1'b1;
    reg_rd(2'd0, rd); check("reset CTRL", rd, 8'h10);
    reg_rd(2'd1, rd); check("reset CONFIG", rd, 8'h00);
    reg_rd(2'd2, rd); check("reset TXBUF", rd, 8'h00);
    reg_rd(2'd3, rd); check("reset RXBUF", rd, 8'h00);

    // Directed table: one byte in each mode
    for (int i = 0; i < 4; i++) begin
      set_mode(vecs[i].mode);
      reg_wr(2'd2, vecs[i].txbuf);
      reg_wr(2'd0, 8'h61);
      cs_low();
      xfer(vecs[i].mode, vecs[i].mosi, 8, r1);
      cs_high();
      check($sformatf("mode%0d master rx", vecs[i].mode), r1, vecs[i].exp_miso);
      reg_rd(2'd3, rd); check($sformatf("mode%0d RXBUF", vecs[i].mode), rd, vecs[i].exp_rxbuf);
      reg_rd(2'd0, rd); check($sformatf("mode%0d CTRL", vecs[i].mode), rd, vecs[i].exp_ctrl);
    end

    // Overrun with interrupt; stale TXBUF retransmitted on byte 2
    set_mode(2'd0);
    reg_wr(2'd2, 8'h99);
    reg_wr(2'd0, 8'h63);
    cs_low();
    check("busy MISO_En", {7'd0, MISO_En}, 8'h01);
    xfer(2'd0, 8'h11, 8, r1);
    xfer(2'd0, 8'h22, 8, r2);
    cs_high();
    check("ovr master rx1", r1, 8'h99);
    check("ovr master rx2", r2, 8'h99);
    reg_rd(2'd3, rd); check("ovr RXBUF", rd, 8'h22);
    reg_rd(2'd0, rd); check("ovr CTRL", rd, 8'h73);
    check("ovr Irq", {7'd0, Irq}, 8'h01);
    reg_wr(2'd0, 8'h61);
    @(negedge Clk);
    check("w1c Irq", {7'd0, Irq}, 8'h00);
    reg_rd(2'd0, rd); check("w1c CTRL", rd, 8'h11);

    // Abort after 4 SCK edges, then a full byte
    cs_low();
    xfer(2'd0, 8'hF0, 2, r1);
    cs_high();
    reg_rd(2'd0, rd); check("abort CTRL", rd, 8'h11);
    reg_rd(2'd3, rd); check("abort RXBUF", rd, 8'h22);
    cs_low();
    xfer(2'd0, 8'h3C, 8, r1);
    cs_high();
    reg_rd(2'd3, rd); check("post-abort RXBUF", rd, 8'h3C);
    reg_rd(2'd0, rd); check("post-abort CTRL", rd, 8'h51);

    // Protection: CONFIG write while busy, then SCK activity with EN=0
    reg_wr(2'd0, 8'h61);
    cs_low();
    reg_rd(2'd0, rd); check("busy CTRL", rd, 8'h91);
    reg_wr(2'd1, 8'h30);
    reg_rd(2'd1, rd); check("busy CONFIG ignored", rd, 8'h00);
    cs_high();
    reg_wr(2'd0, 8'h00);
    cs_low();
    check("disabled MISO_En", {7'd0, MISO_En}, 8'h00);
    xfer(2'd0, 8'h55, 8, r1);
    check("disabled MISO", r1, 8'h00);
    cs_high();
    reg_rd(2'd3, rd); check("disabled RXBUF", rd, 8'h3C);
    reg_rd(2'd0, rd); check("disabled CTRL", rd, 8'h10);

    // Randomized multi-byte transfers against a byte-level model
    for (int t = 0; t < 6; t++) begin
      m   = 2'($urandom_range(0, 3));
      txv = 8'($urandom);
      nb  = $urandom_range(1, 3);
      sent_q.delete();
      reg_wr(2'd0, 8'h61);
      set_mode(m);
      reg_wr(2'd2, txv);
      cs_low();
      for (int k = 0; k < nb; k++) begin
        bv = 8'($urandom);
        sent_q.push_back(bv);
        xfer(m, bv, 8, r1);
        check($sformatf("rand%0d m%0d byte%0d master rx", t, m, k), r1, txv);
      end
      cs_high();
      exp_ctrl = 8'h51 | ((sent_q.size() > 1) ? 8'h20 : 8'h00);
      reg_rd(2'd3, rd); check($sformatf("rand%0d RXBUF", t), rd, sent_q[$]);
      reg_rd(2'd0, rd); check($sformatf("rand%0d CTRL", t), rd, exp_ctrl);
    end

    // Reset in the middle of a byte
    reg_wr(2'd0, 8'h61);
    set_mode(2'd0);
    cs_low();
    xfer(2'd0, 8'hA5, 4, r1);
    @(negedge Clk);
    Rst_n = 1'b0;
    repeat (2) @(negedge Clk);
    Rst_n = 1'b1;
    reg_rd(2'd0, rd); check("midreset CTRL", rd, 8'h10);
    reg_rd(2'd3, rd); check("midreset RXBUF", rd, 8'h00);
    check("midreset MISO_En", {7'd0, MISO_En}, 8'h00);
    cs_high();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
